// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter and issue/capture FSM that shares one ALU among NUM_REQ requesters.
// The winner's operands are registered onto the ALU, and the result is returned tagged with the requester id.
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned OP_W     = 2,
  parameter int unsigned ALU_WAIT = 1,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_c,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      rsp_c,
  output logic                      busy
);

  localparam int unsigned CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_out_q, rsp_out_d;
  logic               rsp_c_q, rsp_c_d;

  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [DATA_W-1:0]  b_arr  [NUM_REQ];
  logic [OP_W-1:0]    op_arr [NUM_REQ];

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
  end

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !rst) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    rsp_id_d  = rsp_id_q;
    rsp_out_d = rsp_out_q;
    rsp_c_d   = rsp_c_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          alu_a_d  = a_arr[grant_id];
          alu_b_d  = b_arr[grant_id];
          alu_op_d = op_arr[grant_id];
          rsp_id_d = grant_id;
          rr_ptr_d = grant_id;
          cnt_d    = CNT_W'(ALU_WAIT - 1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_out_d = alu_out;
          rsp_c_d   = alu_c;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      rsp_id_q  <= '0;
      rsp_out_q <= '0;
      rsp_c_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      rsp_id_q  <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_c_q   <= rsp_c_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a behavioural ALU drives alu_out/alu_c, and the
// expected grants and responses are derived from the round-robin rule and the request operands.
module tb_alu_rr_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [7:0]  req_op = '0;
  logic [3:0]  req_ready;
  logic [3:0]  alu_a, alu_b, alu_out, rsp_out;
  logic [1:0]  alu_op, rsp_id;
  logic        alu_c, rsp_valid, rsp_c, busy;

  logic [3:0]  v3 = '0;
  logic [15:0] a3 = '0, b3 = '0;
  logic [7:0]  op3 = '0;
  logic [3:0]  ready3, alu_a3, alu_b3, rsp_out3;
  logic [3:0]  ao3 = '0;
  logic        ac3 = 1'b0;
  logic [1:0]  alu_op3, rsp_id3;
  logic        rsp_valid3, rsp_c3, busy3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {alu_c, alu_out} = alu_f(alu_a, alu_b, alu_op);

  alu_rr_scheduler #(.NUM_REQ(NR), .DATA_W(4), .OP_W(2), .ALU_WAIT(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_out(alu_out), .alu_c(alu_c), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_c(rsp_c), .busy(busy)
  );

  alu_rr_scheduler #(.NUM_REQ(NR), .DATA_W(4), .OP_W(2), .ALU_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_op(op3), .req_ready(ready3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_op(alu_op3), .alu_out(ao3), .alu_c(ac3), .rsp_valid(rsp_valid3),
    .rsp_id(rsp_id3), .rsp_out(rsp_out3), .rsp_c(rsp_c3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned id;
    logic [4:0]  res;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned grant_log[$];
  int unsigned cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned last_g = NR - 1;
  int unsigned wait_cnt [NR];
  logic [3:0]  last_hs = '0;

  // Monitor: reference arbitration, scoreboard push on grant, pop on response.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned w;
    logic [3:0]  exp_rdy;
    cyc++;
    if (rst) begin
      sbq.delete();
      busy_cnt = 0;
      last_g   = NR - 1;
      last_hs  = '0;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got rsp id %0d with empty scoreboard, required none", rsp_id);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_out", 32'(rsp_out), 32'(e.res[3:0]));
          chk("rsp_c", 32'(rsp_c), 32'(e.res[4]));
          chk("rsp_latency", cyc, e.due);
        end
      end
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("busy", 32'(busy), 32'(busy_cnt != 0));
      if (busy_cnt > 0) begin
        chk("ready_when_busy", 32'(req_ready), 32'd0);
        busy_cnt--;
      end else begin
        exp_rdy = '0;
        w = 0;
        for (int k = 1; k <= NR; k++) begin
          if (exp_rdy == '0 && req_valid[(last_g + k) % NR]) begin
            w = (last_g + k) % NR;
            exp_rdy[w] = 1'b1;
          end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
          e.id  = w;
          e.res = alu_f(req_a[w*4 +: 4], req_b[w*4 +: 4], req_op[w*2 +: 2]);
          e.due = cyc + AW + 1;
          sbq.push_back(e);
          grant_log.push_back(w);
          last_g   = w;
          busy_cnt = AW + 1;
          for (int i = 0; i < NR; i++) begin
            if (i == int'(w)) wait_cnt[i] = 0;
            else if (req_valid[i]) begin
              wait_cnt[i]++;
              chk("starvation", 32'(wait_cnt[i] <= NR - 1), 32'd1);
            end
          end
        end
      end
      for (int i = 0; i < NR; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      last_hs = req_valid & req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    v3 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns just after the edge that accepts the n-th logged grant.
  task automatic wait_grants(input int unsigned n);
    int k = 0;
    while (grant_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (grant_log.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL wait_grant: got %0d grants required %0d", grant_log.size(), n);
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_out", 32'(rsp_out), 0);
    chk("rst_rsp_c", 32'(rsp_c), 0);
    chk("rst_ready", 32'(req_ready), 0);

    // Single ADD from requester 1 with carry out.
    tick();
    req_valid = 4'b0010;
    req_a[7:4] = 4'hF; req_b[7:4] = 4'h1; req_op[3:2] = 2'd0;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_alu_a", 32'(alu_a), 32'hF);
    chk("t1_alu_b", 32'(alu_b), 32'h1);
    chk("t1_ready_off", 32'(req_ready), 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 1);
    chk("t1_rsp_out", 32'(rsp_out), 0);
    chk("t1_rsp_c", 32'(rsp_c), 1);
    repeat (3) tick();

    // All requesters held: strict rotation starting at 0.
    do_reset();
    grant_log.delete();
    req_a = 16'h9C3A; req_b = 16'h5E71; req_op = 8'b00_01_10_11;
    req_valid = 4'b1111;
    wait_grants(5);
    begin
      int unsigned exp_order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) chk("t2_order", grant_log[i], exp_order[i]);
    end
    req_valid = '0;
    repeat (5) tick();

    // Requester 2 held; requester 0 arrives after 2's first grant.
    do_reset();
    grant_log.delete();
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = 4'b0101;
    wait_grants(3);
    chk("t3_first", grant_log[0], 2);
    chk("t3_wrap", grant_log[1], 0);
    chk("t3_again", grant_log[2], 2);
    req_valid = '0;
    repeat (5) tick();

    // Reset during EXEC drops the op.
    do_reset();
    grant_log.delete();
    req_a[3:0] = 4'h7; req_b[3:0] = 4'h6;
    req_valid = 4'b0001;
    wait_grants(1);
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_alu_a", 32'(alu_a), 0);
    chk("t4_alu_b", 32'(alu_b), 0);
    chk("t4_rsp_out", 32'(rsp_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t4_no_rsp", 32'(rsp_valid), 0);
    end
    grant_log.delete();
    req_valid = 4'b1111;
    wait_grants(1);
    chk("t4_next_grant", grant_log[0], 0);
    req_valid = '0;
    repeat (5) tick();

    // ALU_WAIT=3 instance: capture uses the value present in the last EXEC cycle.
    do_reset();
    v3 = 4'b0001; a3[3:0] = 4'hA; b3[3:0] = 4'h5; op3[1:0] = 2'd2;
    @(negedge clk);
    chk("t5_ready", 32'(ready3), 32'b0001);
    tick();
    v3 = '0;
    ao3 = 4'h3; ac3 = 1'b0;
    @(negedge clk);
    chk("t5_alu_a_t1", 32'(alu_a3), 32'hA);
    chk("t5_busy", 32'(busy3), 1);
    chk("t5_nv_t1", 32'(rsp_valid3), 0);
    tick();
    ao3 = 4'hC; ac3 = 1'b0;
    @(negedge clk);
    chk("t5_alu_b_t2", 32'(alu_b3), 32'h5);
    chk("t5_nv_t2", 32'(rsp_valid3), 0);
    tick();
    ao3 = 4'h6; ac3 = 1'b1;
    @(negedge clk);
    chk("t5_alu_op_t3", 32'(alu_op3), 32'd2);
    chk("t5_nv_t3", 32'(rsp_valid3), 0);
    tick();
    ao3 = 4'hF; ac3 = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid3), 1);
    chk("t5_rsp_out", 32'(rsp_out3), 32'h6);
    chk("t5_rsp_c", 32'(rsp_c3), 1);
    chk("t5_rsp_id", 32'(rsp_id3), 0);
    tick();
    @(negedge clk);
    chk("t5_strobe_end", 32'(rsp_valid3), 0);

    // Random traffic: requests held until accepted, occasionally withdrawn.
    do_reset();
    for (int c = 0; c < 15000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_hs[i]) req_valid[i] = 1'b0;
        if (req_valid[i]) begin
          if ($urandom_range(99) < 2) req_valid[i] = 1'b0;
        end else if ($urandom_range(99) < 30) begin
          req_valid[i]      = 1'b1;
          req_a[i*4 +: 4]   = 4'($urandom);
          req_b[i*4 +: 4]   = 4'($urandom);
          req_op[i*2 +: 2]  = 2'($urandom);
        end
      end
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
